nubus_arb_ctrl: RTL
===================

NUBUS_ARB_CTRL -- requirements
Module: nubus_arb_ctrl

Interface
REQ-001 SHALL have parameter ID_W, default 4, arbitration ID width in bits (2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 2, clocks of contest settling before the win is sampled (1..15).
REQ-003 SHALL have parameter FAIR, default 1; 1 enables NuBus fairness lockout, 0 disables it.
REQ-004 SHALL provide ports (active-high logical view of bus lines):
 nub_clk  in  1  sole clock; all state on rising edge
 nub_reset  in  1  synchronous, active-high reset
 id  in  ID_W  card slot ID
 req  in  1  local master requests bus tenure
 done  in  1  local master ends tenure, single-cycle pulse
 rqst_i  in  1  bus RQST line asserted by any card
 start_i  in  1  bus START observed
 ack_i  in  1  bus ACK observed
 arb_i  in  ID_W  sampled bus ARB lines, 1 = asserted
 rqst_o  out  1  drive bus RQST
 arb_o  out  ID_W  ARB drive value
 arb_oe  out  ID_W  per-bit ARB driver enable
 grant  out  1  one-cycle pulse on contest win
 owner  out  1  card holds bus tenure
 locked  out  1  fairness lockout active

Function
REQ-005 SHALL implement states IDLE, LOCK, CONTEST, SETTLE, OWN.
REQ-006 IDLE: req=1 and locked=0 -> CONTEST next cycle; req=1 and locked=1 -> LOCK.
REQ-007 LOCK: remain until rqst_i=0 sampled for one cycle, then clear locked and go to CONTEST if req=1, otherwise IDLE.
REQ-008 CONTEST: rqst_o=1; entered only when bus is idle (start_i=0 and ack_i=0) or on the cycle where ack_i=1 and start_i=0 (last tenure cycle); otherwise hold in CONTEST with arb_oe=0.
REQ-009 Within CONTEST/SETTLE, bit k: arb_oe[k]=1 iff for every j>k, id[j]=1 or arb_i[j]=0; MSB enable is always 1; arb_o[k]=id[k] & arb_oe[k].
REQ-010 SETTLE: counter loads SETTLE_CYC-1 on entry from CONTEST, decrements each cycle; at 0 sample win = AND over all k of (id[k] | ~arb_i[k]).
REQ-011 Win at SETTLE end: grant=1 for exactly that cycle, owner=1 from next cycle, go to OWN, drop rqst_o and all arb_oe.
REQ-012 Loss at SETTLE end: keep rqst_o=1, return to CONTEST awaiting next tenure boundary per REQ-008.
REQ-013 OWN: owner=1 until done=1; on done, owner=0 next cycle, set locked=1 if FAIR=1, go to IDLE.
REQ-014 req falling in CONTEST/SETTLE SHALL abort to IDLE next cycle with rqst_o, arb_oe=0 and no grant.
REQ-015 req falling in OWN SHALL be ignored; only done ends tenure.
REQ-016 done outside OWN SHALL be ignored.
REQ-017 FAIR=0: locked SHALL stay 0 and LOCK SHALL be unreachable.
REQ-018 arb_oe and arb_o SHALL be all-zero in IDLE, LOCK, OWN.

Reset
REQ-019 nub_reset=1 SHALL force IDLE, counter=0, locked=0 and all outputs 0 on next edge, from any state including mid-SETTLE or OWN.
REQ-020 Reset SHALL take priority over done, req and all bus inputs on the same cycle.

Structure
REQ-021 State enum and SETTLE_CYC limits SHALL reside in shared package nubus_pkg.
REQ-022 Per-bit enable/win logic (REQ-009, REQ-010 win term) SHALL be sub-module nubus_arb_prio, parametrised by ID_W, purely combinational.
REQ-023 Counter width SHALL be $clog2(SETTLE_CYC+1), minimum 1.

Verification
REQ-024 ID_W=4, id=4'hA alone, req=1, bus idle -> rqst_o at cycle 1, arb_oe=4'hF, grant pulse after SETTLE_CYC=2 cycles, owner next cycle.
REQ-025 id=4'h5 vs bus arb_i=4'hA -> arb_oe drops to 4'b1000 at bit 2, win=0, no grant, rqst_o held, re-contest on ack_i=1/start_i=0.
REQ-026 FAIR=1: win, done, req held, rqst_i=1 for 5 cycles -> locked=1, rqst_o=0 until rqst_i=0, then CONTEST.
REQ-027 nub_reset=1 during SETTLE with counter=1 -> next cycle all outputs 0, no grant; repeat in OWN -> owner=0.
REQ-028 ID_W=6, SETTLE_CYC=5, id=6'h3F -> grant exactly 5 cycles after CONTEST entry; req drop in SETTLE -> no grant, IDLE.

Source files
------------

// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus arbitration controller: FSM state type and
// legal parameter ranges.
package nubus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_CONTEST,
        ST_SETTLE,
        ST_OWN
    } arb_state_t;

    localparam int SETTLE_CYC_MIN = 1;
    localparam int SETTLE_CYC_MAX = 15;
    localparam int ID_W_MIN       = 2;
    localparam int ID_W_MAX       = 8;

    // Settle counter must hold SETTLE_CYC-1; never narrower than one bit.
    function automatic int settle_cnt_w(input int settle_cyc);
        int w;
        w = $clog2(settle_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nubus_arb_prio.sv
// Combinational NuBus priority resolver: per-bit ARB driver enables and the
// contest win term for a card ID against the sampled ARB lines.
module nubus_arb_prio #(
    parameter int ID_W = 4
) (
    input  logic [ID_W-1:0] id,
    input  logic [ID_W-1:0] arb_i,
    output logic [ID_W-1:0] arb_oe,
    output logic            win
);

    // A bit may drive only while no higher bit has been beaten by another card.
    always_comb begin
        logic still_in;
        still_in = 1'b1;
        arb_oe   = '0;
        for (int k = ID_W - 1; k >= 0; k--) begin
            arb_oe[k] = still_in;
            still_in  = still_in & (id[k] | ~arb_i[k]);
        end
        win = still_in;
    end

endmodule

// File: rtl/nubus_arb_ctrl.sv
// NuBus distributed arbitration controller: requests the bus, contests on the
// ARB lines, holds tenure until done, and applies the fairness lockout.
module nubus_arb_ctrl
    import nubus_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int FAIR       = 1
) (
    input  logic            nub_clk,
    input  logic            nub_reset,
    input  logic [ID_W-1:0] id,
    input  logic            req,
    input  logic            done,
    input  logic            rqst_i,
    input  logic            start_i,
    input  logic            ack_i,
    input  logic [ID_W-1:0] arb_i,
    output logic            rqst_o,
    output logic [ID_W-1:0] arb_o,
    output logic [ID_W-1:0] arb_oe,
    output logic            grant,
    output logic            owner,
    output logic            locked
);

    localparam int              CNT_W    = settle_cnt_w(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < SETTLE_CYC_MIN || SETTLE_CYC > SETTLE_CYC_MAX) begin : g_bad_settle
        $error("nubus_arb_ctrl: SETTLE_CYC out of range");
    end
    if (ID_W < ID_W_MIN || ID_W > ID_W_MAX) begin : g_bad_id_w
        $error("nubus_arb_ctrl: ID_W out of range");
    end

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lost;
    logic             rqst_q;
    logic             owner_q;
    logic             locked_q;

    logic [ID_W-1:0]  prio_oe;
    logic             win;
    logic             boundary;
    logic             driving;

    nubus_arb_prio #(
        .ID_W (ID_W)
    ) u_prio (
        .id     (id),
        .arb_i  (arb_i),
        .arb_oe (prio_oe),
        .win    (win)
    );

    // After a lost contest only the winner's last tenure cycle reopens arbitration.
    assign boundary = lost ? (ack_i & ~start_i) : ~start_i;
    assign driving  = (state == ST_SETTLE) | ((state == ST_CONTEST) & boundary);

    assign arb_oe = driving ? prio_oe : '0;
    assign arb_o  = id & arb_oe;
    assign grant  = (state == ST_SETTLE) & (cnt == '0) & req & win & ~nub_reset;
    assign rqst_o = rqst_q;
    assign owner  = owner_q;
    assign locked = locked_q;

    always_ff @(posedge nub_clk) begin
        if (nub_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lost     <= 1'b0;
            rqst_q   <= 1'b0;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (locked_q) begin
                            state <= ST_LOCK;
                        end else begin
                            state  <= ST_CONTEST;
                            rqst_q <= 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (!rqst_i) begin
                        locked_q <= 1'b0;
                        if (req) begin
                            state  <= ST_CONTEST;
                            rqst_q <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_CONTEST: begin
                    if (!req) begin
                        state  <= ST_IDLE;
                        rqst_q <= 1'b0;
                        lost   <= 1'b0;
                    end else if (boundary) begin
                        state <= ST_SETTLE;
                        cnt   <= CNT_LOAD;
                        lost  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!req) begin
                        state  <= ST_IDLE;
                        rqst_q <= 1'b0;
                        lost   <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == '0) begin
                        if (win) begin
                            state   <= ST_OWN;
                            rqst_q  <= 1'b0;
                            owner_q <= 1'b1;
                        end else begin
                            state <= ST_CONTEST;
                            lost  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_OWN: begin
                    if (done) begin
                        state    <= ST_IDLE;
                        owner_q  <= 1'b0;
                        locked_q <= (FAIR != 0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
